seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Parametrised multiplexed seven-segment scanner for the board top level. Drives NDIG
//  common-anode hex digits from one of NSRC selectable data channels. Adds frame-coherent
//  snapshotting, anti-ghost guard time, PWM brightness, leading-zero blanking and decimal points.
// PARAMETERS
//  NDIG       8    digits driven; display word is NDIG*4 bits
//  NSRC       4    selectable source channels, each NDIG*4 bits
//  SLOT_LOG2  18   log2 of clock cycles per digit slot, minimum 4 (2^18 @100MHz ~ 381 Hz/digit)
//  GUARD_CYC  64   cycles at slot start with all anodes off; must be < 2^SLOT_LOG2
// PORTS
//  CLK100MHZ  in   1                   system clock, all logic on rising edge
//  reset      in   1                   synchronous, active-low
//  en         in   1                   scan enable; 0 freezes the scanner and blanks the display
//  src_sel    in   $clog2(NSRC)        channel select, sampled only in LOAD
//  src_data   in   NSRC*NDIG*4         channel k is [k*NDIG*4 +: NDIG*4]
//  dp_mask    in   NDIG                per-digit decimal point, 1=lit, sampled in LOAD
//  lz_blank   in   1                   leading-zero blanking enable, sampled in LOAD
//  bright     in   4                   brightness 0..15, live input
//  seg        out  7                   segments {g..a}, active-low
//  dp         out  1                   decimal point, active-low
//  an         out  NDIG                anodes, active-low, at most one low at a time
//  frame_tick out  1                   1-cycle pulse in each LOAD cycle
//  cur_digit  out  $clog2(NDIG)        index of the digit whose slot is current
// BEHAVIOUR
//  - Reset (reset=0 at an edge): state=LOAD, digit=0, slot_cnt=0, frame_buf=0.
//    Registered outputs: seg=7'h7F, dp=1, an=all 1, frame_tick=0, cur_digit=0.
//  - FSM advances only when en=1:
//    - LOAD: one cycle. frame_buf<=src_data[src_sel]; latch dp_mask and lz_blank; frame_tick=1;
//      an all 1. Next state is GUARD with digit=0 and slot_cnt=0.
//    - GUARD: slot_cnt<GUARD_CYC. an all 1. Next state is DRIVE when slot_cnt reaches GUARD_CYC.
//    - DRIVE: runs to slot_cnt=2^SLOT_LOG2-1. At slot end, if digit==NDIG-1 go to LOAD,
//      otherwise go to GUARD with digit+1 and slot_cnt=0.
//  - Frame length is NDIG*2^SLOT_LOG2+1 cycles. A src_sel or data change mid-frame has no
//    visible effect until the next LOAD.
//  - Brightness: pwm_phase=slot_cnt[SLOT_LOG2-1 -: 4]. In DRIVE, an[digit]=0 iff
//    pwm_phase<=bright. bright=15 gives the full DRIVE window.
//  - Decode: nibble to segments, 0=1000000, 1=1111001 ... 9=0010000, A=0001000, B=0000011,
//    C=1000110, D=0100001, E=0000110, F=0001110. dp=~dp_latched[digit].
//  - Leading-zero blanking: when lz_blank is latched, digit i is blanked if all nibbles i..NDIG-1
//    are 0, dp for i is 0, and i!=0. A blanked digit keeps its anode high and seg=7'h7F.
//    Digit 0 is never blanked.
//  - seg, dp and an are registered. They change 1 cycle after the state/counter that selects them.
//    an and seg are updated on the same edge, so no glitch reaches a lit digit.
//  - en=0: state, digit and slot_cnt hold; an=all 1, seg=7'h7F, dp=1, frame_tick=0.
//    On en=1 the scanner resumes from the held state.
//  - Reset mid-frame: abandons the current frame; the first enabled cycle after release is LOAD.
//  - slot_cnt is SLOT_LOG2 bits and wraps to 0 at slot end. digit is wrapped via LOAD, never past NDIG-1.
// STRUCTURE
//  - Package seg_pkg holds the FSM enum {S_LOAD,S_GUARD,S_DRIVE}, the SEG_BLANK=7'h7F constant,
//    and the function hex2seg(logic[3:0]) returning logic[6:0].
//  - One sub-module, seg_lz_mask: combinational, takes frame_buf and dp_latched and returns an
//    NDIG-bit blank mask.
//  - All sequential logic stays in seg_scan_ctrl.
// TESTING (NDIG=4, NSRC=2, SLOT_LOG2=4, GUARD_CYC=2)
//  1. reset=0 for 3 cycles -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0. Release with en=1 ->
//     frame_tick=1 on the first cycle; frame_tick then recurs every 65 cycles.
//  2. src0=16'h12AB, bright=15, lz_blank=0 -> digit0 an=4'b1110, seg=7'b0000011 for slot cycles
//     2..15 (+1 register cycle); an=4'hF in guard cycles; digit3 shows 1=7'b1111001.
//  3. lz_blank=1, src0=16'h0050 -> digits 3,2 keep an high with seg=7'h7F; digit1 shows 7'b0010010;
//     digit0 shows 7'b1000000. With src0=0, only digit0 lights, showing 0.
//  4. bright=3 -> an[digit] low only for slot_cnt 2..3 of each slot. bright=0 -> never lit
//     (phase 0 falls inside the guard). Switching bright mid-slot takes effect the next cycle.
//  5. Change src_sel 0->1 mid-frame (src1=16'hFFFF) -> the display is unchanged until the next
//     frame_tick, then all digits show F=7'b0001110. Change dp_mask=4'b0100 -> dp low only in digit2's slot.
//  6. Drop en at digit1 slot_cnt 7 for 10 cycles -> an=4'hF and the counters frozen; resume at
//     slot_cnt 7. Assert reset mid-frame -> the next enabled cycle after release is LOAD, digit 0.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seg_pkg
//  Brief   : Shared types, constants and hex decode for the segment scanner.
//  Revision: 1.0
// ============================================================================
package seg_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_GUARD = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        hex2seg = SEG_BLANK;
        case (nib)
            4'h0: hex2seg = 7'b1000000;
            4'h1: hex2seg = 7'b1111001;
            4'h2: hex2seg = 7'b0100100;
            4'h3: hex2seg = 7'b0110000;
            4'h4: hex2seg = 7'b0011001;
            4'h5: hex2seg = 7'b0010010;
            4'h6: hex2seg = 7'b0000010;
            4'h7: hex2seg = 7'b1111000;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0010000;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b0000011;
            4'hC: hex2seg = 7'b1000110;
            4'hD: hex2seg = 7'b0100001;
            4'hE: hex2seg = 7'b0000110;
            4'hF: hex2seg = 7'b0001110;
            default: hex2seg = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_lz_mask.sv
`default_nettype none
// ============================================================================
//  Module  : seg_lz_mask
//  Brief   : Combinational leading-zero blank mask for the latched frame.
//  Revision: 1.0
// ============================================================================
module seg_lz_mask
#(
    parameter int NDIG = 8
)(
    input  logic [NDIG*4-1:0] i_frame_buf,
    input  logic [NDIG-1:0]   i_dp_latched,
    output logic [NDIG-1:0]   o_blank_mask
);

    // w_zero_above[i] is set when nibbles i..NDIG-1 are all zero.
    logic [NDIG:0] w_zero_above;

    assign w_zero_above[NDIG] = 1'b1;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        assign w_zero_above[i] = w_zero_above[i+1] && (i_frame_buf[i*4 +: 4] == 4'h0);
        if (i == 0) begin : g_first
            assign o_blank_mask[i] = 1'b0;
        end else begin : g_rest
            assign o_blank_mask[i] = w_zero_above[i] && !i_dp_latched[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : seg_scan_ctrl
//  Brief   : Multiplexed seven-segment scanner with frame snapshot, guard
//            time, PWM brightness, leading-zero blanking and decimal points.
//  Revision: 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG      = 8,
    parameter int NSRC      = 4,
    parameter int SLOT_LOG2 = 18,
    parameter int GUARD_CYC = 64
)(
    input  logic                      CLK100MHZ,
    input  logic                      reset,
    input  logic                      en,
    input  logic [$clog2(NSRC)-1:0]   src_sel,
    input  logic [NSRC*NDIG*4-1:0]    src_data,
    input  logic [NDIG-1:0]           dp_mask,
    input  logic                      lz_blank,
    input  logic [3:0]                bright,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NDIG-1:0]           an,
    output logic                      frame_tick,
    output logic [$clog2(NDIG)-1:0]   cur_digit
);

    localparam int DW  = NDIG * 4;
    localparam int DGW = $clog2(NDIG);
    localparam logic [SLOT_LOG2-1:0] c_guard_last = SLOT_LOG2'(GUARD_CYC - 1);
    localparam logic [SLOT_LOG2-1:0] c_slot_last  = '1;
    localparam logic [DGW-1:0]       c_digit_last = DGW'(NDIG - 1);

    state_t                r_state, w_state_nxt;
    logic [DGW-1:0]        r_digit, w_digit_nxt;
    logic [SLOT_LOG2-1:0]  r_slot_cnt, w_slot_nxt;
    logic [DW-1:0]         r_frame_buf;
    logic [NDIG-1:0]       r_dp_latched;
    logic                  r_lz_latched;
    logic [6:0]            r_seg, w_seg_nxt;
    logic                  r_dp, w_dp_nxt;
    logic [NDIG-1:0]       r_an, w_an_nxt;
    logic                  r_frame_tick;

    logic [NDIG-1:0]       w_blank_mask;
    logic [3:0]            w_nib;
    logic [3:0]            w_pwm_phase;
    logic                  w_drive;

    seg_lz_mask #(.NDIG(NDIG)) u_lz_mask (
        .i_frame_buf  (r_frame_buf),
        .i_dp_latched (r_dp_latched),
        .o_blank_mask (w_blank_mask)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_slot_nxt  = r_slot_cnt;
        case (r_state)
            S_LOAD: begin
                w_state_nxt = S_GUARD;
                w_digit_nxt = '0;
                w_slot_nxt  = '0;
            end
            S_GUARD: begin
                w_slot_nxt = r_slot_cnt + 1'b1;
                if (r_slot_cnt == c_guard_last)
                    w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                w_slot_nxt = r_slot_cnt + 1'b1;
                if (r_slot_cnt == c_slot_last) begin
                    if (r_digit == c_digit_last) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_GUARD;
                        w_digit_nxt = r_digit + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Output selection from the current state; registered on the next edge.
    always_comb begin
        w_nib       = r_frame_buf[4*r_digit +: 4];
        w_pwm_phase = r_slot_cnt[SLOT_LOG2-1 -: 4];
        w_drive     = en && (r_state == S_DRIVE) && !(r_lz_latched && w_blank_mask[r_digit]);
        w_seg_nxt   = SEG_BLANK;
        w_dp_nxt    = 1'b1;
        w_an_nxt    = '1;
        if (w_drive) begin
            w_seg_nxt = hex2seg(w_nib);
            w_dp_nxt  = ~r_dp_latched[r_digit];
            if (w_pwm_phase <= bright)
                w_an_nxt[r_digit] = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_digit      <= '0;
            r_slot_cnt   <= '0;
            r_frame_buf  <= '0;
            r_dp_latched <= '0;
            r_lz_latched <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_an         <= w_an_nxt;
            r_frame_tick <= en && (r_state == S_LOAD);
            if (en) begin
                r_state    <= w_state_nxt;
                r_digit    <= w_digit_nxt;
                r_slot_cnt <= w_slot_nxt;
                if (r_state == S_LOAD) begin
                    r_frame_buf  <= src_data[src_sel*DW +: DW];
                    r_dp_latched <= dp_mask;
                    r_lz_latched <= lz_blank;
                end
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;
    assign cur_digit  = r_digit;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seg_scan_ctrl
//  Brief   : Self-checking bench for seg_scan_ctrl against a frame-position model.
//  Revision: 1.0
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int NDIG = 4, NSRC = 2, SLOT_LOG2 = 4, GUARD_CYC = 2;
    localparam int SLOT = 16, FRAME = NDIG * SLOT + 1;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b0;
    logic        en        = 1'b0;
    logic [0:0]  src_sel   = '0;
    logic [31:0] src_data  = '0;
    logic [3:0]  dp_mask   = '0;
    logic        lz_blank  = 1'b0;
    logic [3:0]  bright    = 4'hF;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;
    logic [1:0]  cur_digit;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    seg_scan_ctrl #(.NDIG(NDIG), .NSRC(NSRC), .SLOT_LOG2(SLOT_LOG2), .GUARD_CYC(GUARD_CYC)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .en        (en),
        .src_sel   (src_sel),
        .src_data  (src_data),
        .dp_mask   (dp_mask),
        .lz_blank  (lz_blank),
        .bright    (bright),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_tick(frame_tick),
        .cur_digit (cur_digit)
    );

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Model: pos is the position within the frame (0 = load, then NDIG slots of SLOT cycles).
    int          pos   = 0;
    int          shown = -1;
    int          mdig  = 0;
    logic [15:0] mbuf  = '0;
    logic [3:0]  mdp   = '0;
    logic        mlz   = 1'b0;
    logic [14:0] e_vec = '0;
    wire  [14:0] obs   = {an, seg, dp, frame_tick, cur_digit};

    always @(posedge CLK100MHZ) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_ft, blank;
        int         d, s;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0; shown = -1;
        if (!reset) begin
            pos = 0; mdig = 0; mbuf = '0; mdp = '0; mlz = 1'b0;
        end else if (en) begin
            shown = pos;
            if (pos == 0) begin
                e_ft = 1'b1;
                mbuf = src_data[src_sel*16 +: 16];
                mdp  = dp_mask;
                mlz  = lz_blank;
            end else begin
                d = (pos - 1) / SLOT;
                s = (pos - 1) % SLOT;
                blank = mlz && (d != 0) && ((mbuf >> (4*d)) == 16'h0) && !mdp[d];
                if (s >= GUARD_CYC && !blank) begin
                    e_seg = seg_tab[mbuf[4*d +: 4]];
                    e_dp  = !mdp[d];
                    if ((s >> (SLOT_LOG2 - 4)) <= int'(bright))
                        e_an[d] = 1'b0;
                end
            end
            pos = (pos + 1) % FRAME;
            if (pos != 0)
                mdig = (pos - 1) / SLOT;
        end
        e_vec = {e_an, e_seg, e_dp, e_ft, 2'(mdig)};
    end

    task automatic wait_pos(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK100MHZ);
            if (pos == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit found;
        reset = 1'b0; en = 1'b1;
        repeat (3) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL reset_state: got %h required %h", {an, seg, dp, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
        end
        reset = 1'b1;
        @(negedge CLK100MHZ);
        n_checks++;
        if (frame_tick !== 1'b1 || cur_digit !== 2'd0) begin
            n_errors++;
            $display("FAIL first_tick: got ft=%b dig=%0d required ft=1 dig=0", frame_tick, cur_digit);
        end
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK100MHZ);
            cnt++;
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL reset_model: got %h required %h", obs, e_vec);
            end
            if (frame_tick === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found || cnt != FRAME) begin
            n_errors++;
            $display("FAIL tick_period: got %0d required %0d", cnt, FRAME);
        end
    endtask

    task automatic test_decode();
        bit ok;
        src_data = {16'h0000, 16'h12AB}; src_sel = '0; bright = 4'hF; lz_blank = 1'b0; dp_mask = '0;
        wait_pos(0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL decode_wait: got timeout required frame start"); end
        wait_pos(0, ok);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL decode_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
            if (shown == 3) begin
                n_checks++;
                if (an !== 4'b1110 || seg !== 7'b0000011) begin
                    n_errors++;
                    $display("FAIL decode_digit0: got an=%b seg=%b required an=1110 seg=0000011", an, seg);
                end
            end
            if (shown == 1) begin
                n_checks++;
                if (an !== 4'hF) begin
                    n_errors++;
                    $display("FAIL decode_guard: got an=%b required an=1111", an);
                end
            end
            if (shown == 54) begin
                n_checks++;
                if (an !== 4'b0111 || seg !== 7'b1111001) begin
                    n_errors++;
                    $display("FAIL decode_digit3: got an=%b seg=%b required an=0111 seg=1111001", an, seg);
                end
            end
        end
    endtask

    task automatic test_lz_blank();
        bit ok;
        lz_blank = 1'b1; src_data = {16'h0000, 16'h0050}; bright = 4'hF; dp_mask = '0;
        wait_pos(0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL lz_wait: got timeout required frame start"); end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL lz_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
            if (shown == 54 || shown == 38) begin
                n_checks++;
                if (an !== 4'hF || seg !== 7'h7F) begin
                    n_errors++;
                    $display("FAIL lz_blanked: pos=%0d got an=%b seg=%b required an=1111 seg=1111111", shown, an, seg);
                end
            end
            if (shown == 22) begin
                n_checks++;
                if (an !== 4'b1101 || seg !== 7'b0010010) begin
                    n_errors++;
                    $display("FAIL lz_digit1: got an=%b seg=%b required an=1101 seg=0010010", an, seg);
                end
            end
        end
        src_data = '0;
        wait_pos(0, ok);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL lz_zero_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
            if (shown >= 1 + SLOT) begin
                n_checks++;
                if (an !== 4'hF) begin
                    n_errors++;
                    $display("FAIL lz_zero_upper: pos=%0d got an=%b required an=1111", shown, an);
                end
            end
            if (shown == 6) begin
                n_checks++;
                if (an !== 4'b1110 || seg !== 7'b1000000) begin
                    n_errors++;
                    $display("FAIL lz_zero_digit0: got an=%b seg=%b required an=1110 seg=1000000", an, seg);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_brightness();
        bit ok;
        int lit;
        src_data = {16'h0000, 16'h8888};
        for (int b = 0; b < 2; b++) begin
            bright = (b == 0) ? 4'd3 : 4'd0;
            wait_pos(0, ok);
            lit = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge CLK100MHZ);
                n_checks++;
                if (obs !== e_vec) begin
                    n_errors++;
                    $display("FAIL bright_model: pos=%0d got %h required %h", shown, obs, e_vec);
                end
                if (an !== 4'hF) lit++;
            end
            n_checks++;
            if (lit != ((b == 0) ? 2 * NDIG : 0)) begin
                n_errors++;
                $display("FAIL bright_lit_count: bright=%0d got %0d required %0d", bright, lit, (b == 0) ? 2 * NDIG : 0);
            end
        end
        bright = 4'd3;
        wait_pos(6, ok);
        bright = 4'hF;
        @(negedge CLK100MHZ);
        n_checks++;
        if (an !== 4'b1110) begin
            n_errors++;
            $display("FAIL bright_switch_on: got an=%b required an=1110", an);
        end
        bright = 4'd3;
        @(negedge CLK100MHZ);
        n_checks++;
        if (an !== 4'hF) begin
            n_errors++;
            $display("FAIL bright_switch_off: got an=%b required an=1111", an);
        end
        bright = 4'hF;
    endtask

    task automatic test_src_switch();
        bit ok;
        src_data = {16'hFFFF, 16'h1234}; src_sel = '0; dp_mask = '0; bright = 4'hF;
        wait_pos(0, ok);
        wait_pos(0, ok);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec || (an !== 4'hF && seg === 7'b0001110)) begin
                n_errors++;
                $display("FAIL src_hold: pos=%0d got %h required %h", shown, obs, e_vec);
            end
            if (i == 20) begin
                src_sel = 1'b1;
                dp_mask = 4'b0100;
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL src_new_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
            if (an !== 4'hF) begin
                n_checks++;
                if (seg !== 7'b0001110 || ((dp === 1'b0) != (an === 4'b1011))) begin
                    n_errors++;
                    $display("FAIL src_new_digits: pos=%0d got an=%b seg=%b dp=%b required seg=0001110 dp low only in digit2", shown, an, seg, dp);
                end
            end
        end
        dp_mask = '0;
    endtask

    task automatic test_enable_freeze();
        bit ok;
        bright = 4'hF;
        wait_pos(1 + SLOT + 7, ok);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec || {an, seg, dp, frame_tick, cur_digit} !== {4'hF, 7'h7F, 1'b1, 1'b0, 2'd1}) begin
                n_errors++;
                $display("FAIL en_freeze: got %h required %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 2'd1});
            end
        end
        en = 1'b1;
        @(negedge CLK100MHZ);
        n_checks++;
        if (an !== 4'b1101 || shown != 1 + SLOT + 7) begin
            n_errors++;
            $display("FAIL en_resume: got an=%b required an=1101", an);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL en_resume_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_pos(30, ok);
        reset = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        reset = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL rst_mid_idle: got %h required %h", obs, e_vec);
            end
        end
        en = 1'b1;
        @(negedge CLK100MHZ);
        n_checks++;
        if (frame_tick !== 1'b1 || cur_digit !== 2'd0) begin
            n_errors++;
            $display("FAIL rst_mid_load: got ft=%b dig=%0d required ft=1 dig=0", frame_tick, cur_digit);
        end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL rst_mid_model: pos=%0d got %h required %h", shown, obs, e_vec);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int i = 0; i < 600; i++) begin
            v = '0;
            for (int n = 0; n < 8; n++)
                if ($urandom_range(0, 1) == 1) v[4*n +: 4] = 4'($urandom);
            src_data = v;
            src_sel  = 1'($urandom);
            dp_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_blank = 1'($urandom);
            bright   = 4'($urandom);
            en       = ($urandom_range(0, 9) != 0);
            reset    = ($urandom_range(0, 199) != 0);
            @(negedge CLK100MHZ);
            n_checks++;
            if (obs !== e_vec) begin
                n_errors++;
                $display("FAIL random_model: cycle=%0d got %h required %h", i, obs, e_vec);
            end
        end
        reset = 1'b1; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_lz_blank();
        test_brightness();
        test_src_switch();
        test_enable_freeze();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
